// File: rtl/rlwe_fifo_pkg.sv
// Shared types and default sizing for the multi-polynomial RLWE input buffer.
package rlwe_fifo_pkg;

    localparam int DEF_POINTER_WIDTH = 2;
    localparam int DEF_POLY_LINES    = 256;

    typedef enum logic {
        MODE_BOOTSTRAP = 1'b0,
        MODE_STREAM    = 1'b1
    } mode_e;

    typedef logic [DEF_POINTER_WIDTH:0]          slot_ptr_t;
    typedef logic [$clog2(DEF_POLY_LINES)-1:0]   line_addr_t;

endpackage

// File: rtl/rlwe_poly_slot_ram.sv
// One polynomial channel's slot storage: single write port, three registered read ports.
module rlwe_poly_slot_ram
    import rlwe_fifo_pkg::*;
#(
    parameter int LINE_W = 64,
    parameter int AW     = 10,
    parameter int DEPTH  = 1024
)(
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic              rd_en_d,
    input  logic [AW-1:0]     raddr_d,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [LINE_W-1:0] rdata_d,
    output logic [LINE_W-1:0] rdata_a,
    output logic [LINE_W-1:0] rdata_b
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads sample the array before this edge's write lands, so a colliding read sees old data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_d <= '0;
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (rd_en_d) begin
                rdata_d <= mem[raddr_d];
            end
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/rlwe_multi_poly_fifo.sv
// Global RLWE input buffer: NUM_POLY channel rings of polynomial slots, DMA or accumulator fed.
// Optional status outputs (occupancy, err_overflow) are enabled with RLWE_FIFO_STATUS_EN.
module rlwe_multi_poly_fifo
    import rlwe_fifo_pkg::*;
#(
    parameter int NUM_POLY      = 2,
    parameter int POINTER_WIDTH = DEF_POINTER_WIDTH,
    parameter int BUFFER_DEPTH  = 2**POINTER_WIDTH,
    parameter int BIT_WIDTH     = 16,
    parameter int LINE_SIZE     = 4,
    parameter int LINE_W        = BIT_WIDTH*LINE_SIZE,
    parameter int POLY_LINES    = DEF_POLY_LINES,
    parameter int LINE_AW       = $clog2(POLY_LINES)
)(
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         mode_req,
    output logic                         mode,
    input  logic [NUM_POLY-1:0]          dma_wr_valid,
    output logic [NUM_POLY-1:0]          dma_wr_ready,
    input  logic [NUM_POLY*LINE_W-1:0]   dma_wr_data,
    input  logic                         dma_rd_en,
    input  logic [LINE_AW-1:0]           dma_rd_addr,
    output logic [NUM_POLY*LINE_W-1:0]   dma_rd_data,
    input  logic [NUM_POLY-1:0]          int_wr_en,
    input  logic [NUM_POLY*LINE_AW-1:0]  int_wr_addr,
    input  logic [NUM_POLY*LINE_W-1:0]   int_wr_data,
    input  logic                         int_wr_done,
    input  logic [LINE_AW-1:0]           int_rd_addr_a,
    input  logic [LINE_AW-1:0]           int_rd_addr_b,
    output logic [NUM_POLY*LINE_W-1:0]   int_rd_dout_a,
    output logic [NUM_POLY*LINE_W-1:0]   int_rd_dout_b,
    input  logic                         rd_release,
    output logic                         empty,
    output logic                         full
`ifdef RLWE_FIFO_STATUS_EN
    ,
    output logic [POINTER_WIDTH:0]       occupancy,
    output logic                         err_overflow
`endif
);

    localparam int RAM_AW    = POINTER_WIDTH + LINE_AW;
    localparam int RAM_DEPTH = BUFFER_DEPTH * POLY_LINES;
    localparam logic [LINE_AW:0] LINES_FULL = (LINE_AW+1)'(POLY_LINES);

    logic [POINTER_WIDTH:0]   wr_ptr, rd_ptr;
    logic [POINTER_WIDTH-1:0] wr_idx, rd_idx;
    logic [LINE_AW:0]         line_cnt [NUM_POLY];
    mode_e                    mode_q;
    logic                     ready_en;

    logic                     stream;
    logic                     any_partial, all_done;
    logic                     release_ok, commit_stream, commit_int, commit;
    logic [NUM_POLY-1:0]      beat;
    logic [NUM_POLY-1:0]      ram_we;
    logic [RAM_AW-1:0]        ram_waddr [NUM_POLY];
    logic [LINE_W-1:0]        ram_wdata [NUM_POLY];
    logic [RAM_AW-1:0]        raddr_d, raddr_a, raddr_b;

    assign wr_idx = wr_ptr[POINTER_WIDTH-1:0];
    assign rd_idx = rd_ptr[POINTER_WIDTH-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[POINTER_WIDTH] != rd_ptr[POINTER_WIDTH]);
    assign mode   = mode_q;
    assign stream = (mode_q == MODE_STREAM);

    assign raddr_d = {rd_idx, dma_rd_addr};
    assign raddr_a = {rd_idx, int_rd_addr_a};
    assign raddr_b = {rd_idx, int_rd_addr_b};

    // A full buffer may still take a commit when the head is freed in the same cycle.
    assign release_ok    = rd_release && !empty;
    assign commit_stream = stream && all_done;
    assign commit_int    = !stream && int_wr_done && (!full || rd_release);
    assign commit        = commit_stream || commit_int;

    always_comb begin
        any_partial = 1'b0;
        all_done    = 1'b1;
        for (int c = 0; c < NUM_POLY; c++) begin
            if (line_cnt[c] != '0) begin
                any_partial = 1'b1;
            end
            if (line_cnt[c] != LINES_FULL) begin
                all_done = 1'b0;
            end
        end
    end

    always_comb begin
        dma_wr_ready = '0;
        beat         = '0;
        ram_we       = '0;
        for (int c = 0; c < NUM_POLY; c++) begin
            ram_waddr[c] = '0;
            ram_wdata[c] = '0;
            dma_wr_ready[c] = ready_en && stream && !full && (line_cnt[c] != LINES_FULL);
            beat[c]         = dma_wr_ready[c] && dma_wr_valid[c];
            if (stream) begin
                ram_we[c]    = beat[c];
                ram_waddr[c] = {wr_idx, line_cnt[c][LINE_AW-1:0]};
                ram_wdata[c] = dma_wr_data[c*LINE_W +: LINE_W];
            end else begin
                ram_we[c]    = int_wr_en[c];
                ram_waddr[c] = {wr_idx, int_wr_addr[c*LINE_AW +: LINE_AW]};
                ram_wdata[c] = int_wr_data[c*LINE_W +: LINE_W];
            end
        end
    end

    // The mode only switches with nothing committed and no slot half-streamed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mode_q   <= MODE_STREAM;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (release_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (empty && !any_partial) begin
                mode_q <= mode_e'(mode_req);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_POLY; c++) begin
                line_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_POLY; c++) begin
                if (commit_stream) begin
                    line_cnt[c] <= '0;
                end else if (beat[c]) begin
                    line_cnt[c] <= line_cnt[c] + 1'b1;
                end
            end
        end
    end

`ifdef RLWE_FIFO_STATUS_EN
    assign occupancy = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_overflow <= 1'b0;
        end else if ((!stream && int_wr_done && full && !rd_release) || (rd_release && empty)) begin
            err_overflow <= 1'b1;
        end
    end
`endif

    for (genvar c = 0; c < NUM_POLY; c++) begin : g_chan
        rlwe_poly_slot_ram #(
            .LINE_W (LINE_W),
            .AW     (RAM_AW),
            .DEPTH  (RAM_DEPTH)
        ) u_ram (
            .clk     (clk),
            .rstn    (rstn),
            .we      (ram_we[c]),
            .waddr   (ram_waddr[c]),
            .wdata   (ram_wdata[c]),
            .rd_en_d (dma_rd_en),
            .raddr_d (raddr_d),
            .raddr_a (raddr_a),
            .raddr_b (raddr_b),
            .rdata_d (dma_rd_data[c*LINE_W +: LINE_W]),
            .rdata_a (int_rd_dout_a[c*LINE_W +: LINE_W]),
            .rdata_b (int_rd_dout_b[c*LINE_W +: LINE_W])
        );
    end

endmodule

// File: tb/tb_rlwe_multi_poly_fifo.sv
// Scoreboard bench for rlwe_multi_poly_fifo with a slot-level FIFO reference model.
module tb_rlwe_multi_poly_fifo;
    import rlwe_fifo_pkg::*;

    localparam int NP    = 2;
    localparam int PW    = 2;
    localparam int DEPTH = 4;
    localparam int LW    = 64;
    localparam int PL    = 256;
    localparam int LAW   = 8;
    localparam int BW    = NP*LW;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            mode_req = 1'b1;
    logic            mode;
    logic [NP-1:0]   dma_wr_valid = '0;
    logic [NP-1:0]   dma_wr_ready;
    logic [BW-1:0]   dma_wr_data = '0;
    logic            dma_rd_en = 1'b0;
    logic [LAW-1:0]  dma_rd_addr = '0;
    logic [BW-1:0]   dma_rd_data;
    logic [NP-1:0]   int_wr_en = '0;
    logic [NP*LAW-1:0] int_wr_addr = '0;
    logic [BW-1:0]   int_wr_data = '0;
    logic            int_wr_done = 1'b0;
    logic [LAW-1:0]  int_rd_addr_a = '0;
    logic [LAW-1:0]  int_rd_addr_b = '0;
    logic [BW-1:0]   int_rd_dout_a, int_rd_dout_b;
    logic            rd_release = 1'b0;
    logic            empty, full;
`ifdef RLWE_FIFO_STATUS_EN
    logic [PW:0]     occupancy;
    logic            err_overflow;
`endif

    rlwe_multi_poly_fifo #(
        .NUM_POLY(NP), .POINTER_WIDTH(PW), .BIT_WIDTH(16), .LINE_SIZE(4), .POLY_LINES(PL)
    ) dut (
        .clk(clk), .rstn(rstn), .mode_req(mode_req), .mode(mode),
        .dma_wr_valid(dma_wr_valid), .dma_wr_ready(dma_wr_ready), .dma_wr_data(dma_wr_data),
        .dma_rd_en(dma_rd_en), .dma_rd_addr(dma_rd_addr), .dma_rd_data(dma_rd_data),
        .int_wr_en(int_wr_en), .int_wr_addr(int_wr_addr), .int_wr_data(int_wr_data),
        .int_wr_done(int_wr_done), .int_rd_addr_a(int_rd_addr_a), .int_rd_addr_b(int_rd_addr_b),
        .int_rd_dout_a(int_rd_dout_a), .int_rd_dout_b(int_rd_dout_b),
        .rd_release(rd_release), .empty(empty), .full(full)
`ifdef RLWE_FIFO_STATUS_EN
        , .occupancy(occupancy), .err_overflow(err_overflow)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: slot contents plus commit/release totals.
    logic [LW-1:0] m_mem [NP][DEPTH][PL];
    int            m_commits = 0;
    int            m_releases = 0;
    int            m_line [NP];

    logic [BW-1:0] q_d[$], q_a[$], q_b[$];
    logic req_d = 1'b0, req_a = 1'b0, req_b = 1'b0;
    logic vd_p1 = 1'b0, va_p1 = 1'b0, vb_p1 = 1'b0;

    function automatic int occ();
        return m_commits - m_releases;
    endfunction

    function automatic logic [BW-1:0] exp_line(input int slot, input int line);
        logic [BW-1:0] r;
        for (int c = 0; c < NP; c++) r[c*LW +: LW] = m_mem[c][slot][line];
        return r;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: read data appears one cycle after the request.
    always @(posedge clk) begin
        vd_p1 <= req_d;
        va_p1 <= req_a;
        vb_p1 <= req_b;
    end

    always @(negedge clk) begin
        if (vd_p1) begin
            if (q_d.size() == 0) begin n_cmp++; n_bad++; $display("FAIL rd_dma: data with no expected entry"); end
            else check("rd_dma", dma_rd_data, q_d.pop_front());
        end
        if (va_p1) begin
            if (q_a.size() == 0) begin n_cmp++; n_bad++; $display("FAIL rd_a: data with no expected entry"); end
            else check("rd_a", int_rd_dout_a, q_a.pop_front());
        end
        if (vb_p1) begin
            if (q_b.size() == 0) begin n_cmp++; n_bad++; $display("FAIL rd_b: data with no expected entry"); end
            else check("rd_b", int_rd_dout_b, q_b.pop_front());
        end
    end

    task automatic issue_reads(input int n);
        if (occ() == 0) return;
        for (int i = 0; i < n; i++) begin
            dma_rd_addr   = LAW'($urandom_range(PL-1));
            int_rd_addr_a = LAW'($urandom_range(PL-1));
            int_rd_addr_b = LAW'($urandom_range(PL-1));
            req_d = 1'($urandom_range(1));
            dma_rd_en = req_d;
            req_a = 1'b1;
            req_b = 1'b1;
            if (req_d) q_d.push_back(exp_line(m_releases % DEPTH, int'(dma_rd_addr)));
            q_a.push_back(exp_line(m_releases % DEPTH, int'(int_rd_addr_a)));
            q_b.push_back(exp_line(m_releases % DEPTH, int'(int_rd_addr_b)));
            step();
        end
        req_a = 1'b0; req_b = 1'b0; req_d = 1'b0; dma_rd_en = 1'b0;
    endtask

    task automatic read_ab(input int a, input int b);
        int_rd_addr_a = LAW'(a);
        int_rd_addr_b = LAW'(b);
        req_a = 1'b1; req_b = 1'b1;
        q_a.push_back(exp_line(m_releases % DEPTH, a));
        q_b.push_back(exp_line(m_releases % DEPTH, b));
        step();
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic release_head();
        rd_release = 1'b1;
        step();
        rd_release = 1'b0;
        if (occ() > 0) m_releases++;
    endtask

    // Stream one slot channel by channel; stop_at>=0 abandons ch0 at that line.
    task automatic stream_slot(input int stop_at);
        int stall;
        logic rdy, acc;
        logic [LW-1:0] d;
        for (int c = 0; c < NP; c++) begin
            stall = 0;
            while (m_line[c] < PL) begin
                if (c == 0 && m_line[0] == stop_at) begin dma_wr_valid = '0; return; end
                if (c == 1 && m_line[1] == 0 && stall == 0) check("ready_ch0_done", BW'(dma_wr_ready[0]), '0);
                dma_wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
                dma_wr_valid = '0;
                dma_wr_valid[c] = ($urandom_range(3) != 0);
                rdy = dma_wr_ready[c];
                acc = rdy && dma_wr_valid[c];
                d = dma_wr_data[c*LW +: LW];
                step();
                if (acc) begin
                    m_mem[c][m_commits % DEPTH][m_line[c]] = d;
                    m_line[c]++;
                    stall = 0;
                end else if (!rdy) begin
                    stall++;
                    if (stall > 50) begin
                        n_cmp++; n_bad++;
                        $display("FAIL stream_stall ch%0d: ready low %0d cycles, expected high", c, stall);
                        dma_wr_valid = '0;
                        return;
                    end
                end
            end
        end
        dma_wr_valid = '0;
        check("pre_commit_empty", BW'(empty), BW'(occ() == 0));
        step();
        m_commits++;
        for (int c = 0; c < NP; c++) m_line[c] = 0;
        check("post_commit_empty", BW'(empty), '0);
        check("post_commit_full", BW'(full), BW'(occ() == DEPTH));
    endtask

    task automatic int_fill_slot();
        int a;
        for (int l = 0; l < PL + 16; l++) begin
            int_wr_en = (l < PL) ? '1 : NP'($urandom_range(3));
            for (int c = 0; c < NP; c++) begin
                a = (l >= PL) ? $urandom_range(PL-1) : ((c % 2 == 0) ? l : PL-1-l);
                int_wr_addr[c*LAW +: LAW] = LAW'(a);
                int_wr_data[c*LW +: LW] = {$urandom(), $urandom()};
            end
            step();
            for (int c = 0; c < NP; c++)
                if (int_wr_en[c])
                    m_mem[c][m_commits % DEPTH][int'(int_wr_addr[c*LAW +: LAW])] = int_wr_data[c*LW +: LW];
        end
        int_wr_en = '0;
        int_wr_done = 1'b1;
        step();
        int_wr_done = 1'b0;
        if (occ() < DEPTH) m_commits++;
        check("int_commit_empty", BW'(empty), '0);
        check("int_commit_full", BW'(full), BW'(occ() == DEPTH));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NP; c++) m_line[c] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", BW'(empty), BW'(1));
        check("rst_full", BW'(full), '0);
        check("rst_mode", BW'(mode), BW'(1));
        check("rst_ready", BW'(dma_wr_ready), '0);
        check("rst_dma_rd", dma_rd_data, '0);
        check("rst_dout_a", int_rd_dout_a, '0);
        check("rst_dout_b", int_rd_dout_b, '0);
        rstn = 1'b1;
        step();

        // DMA streaming, first slot then fill to full
        stream_slot(-1);
        issue_reads(20);
        repeat (3) stream_slot(-1);
        check("full_after_4", BW'(full), BW'(1));
        check("ready_when_full", BW'(dma_wr_ready), '0);
        dma_wr_valid = '1;
        repeat (3) step();
        dma_wr_valid = '0;
        check("full_held", BW'(full), BW'(1));
        issue_reads(20);
        release_head();
        check("full_after_release", BW'(full), '0);
        check("ready_after_release", BW'(dma_wr_ready), BW'(2'b11));
        issue_reads(10);

        // Mode request is held off until the buffer drains
        mode_req = 1'b0;
        repeat (2) step();
        check("mode_held", BW'(mode), BW'(1));
        while (occ() > 0) begin
            issue_reads(8);
            release_head();
        end
        check("mode_at_empty", BW'(mode), BW'(1));
        step();
        check("mode_switched", BW'(mode), '0);
        check("ready_mode0", BW'(dma_wr_ready), '0);
        release_head();
        check("release_empty_ignored", BW'(empty), BW'(1));
`ifdef RLWE_FIFO_STATUS_EN
        check("err_overflow", BW'(err_overflow), BW'(1));
        check("occupancy_empty", BW'(occupancy), '0);
`endif

        // Accumulator writes
        int_fill_slot();
        read_ab(5, 9);
        issue_reads(20);
        repeat (3) int_fill_slot();
        check("int_full", BW'(full), BW'(1));
        int_wr_done = 1'b1;
        step();
        int_wr_done = 1'b0;
        check("done_when_full_dropped", BW'(full), BW'(1));
        issue_reads(10);
        int_wr_done = 1'b1;
        rd_release = 1'b1;
        step();
        int_wr_done = 1'b0;
        rd_release = 1'b0;
        m_commits++;
        m_releases++;
        check("commit_release_full", BW'(full), BW'(1));
`ifdef RLWE_FIFO_STATUS_EN
        check("occupancy_full", BW'(occupancy), BW'(4));
`endif
        issue_reads(20);
        while (occ() > 0) begin
            issue_reads(8);
            release_head();
        end
        check("drained_empty", BW'(empty), BW'(1));
        mode_req = 1'b1;
        step();
        check("mode_back_stream", BW'(mode), BW'(1));

        // Reset in the middle of a stream
        stream_slot(100);
        rstn = 1'b0;
        #2;
        check("midrst_empty", BW'(empty), BW'(1));
        check("midrst_full", BW'(full), '0);
        check("midrst_ready", BW'(dma_wr_ready), '0);
        check("midrst_dout_a", int_rd_dout_a, '0);
        m_commits = 0;
        m_releases = 0;
        for (int c = 0; c < NP; c++) m_line[c] = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
        stream_slot(-1);
        issue_reads(30);

        repeat (4) step();
        check("queues_drained", BW'(q_a.size() + q_b.size() + q_d.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
